debouncer_multi: RTL and testbench



---
 rtl/debouncer_multi.sv | 100 ++++++++++
 tb/tb_debouncer_multi.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel synchronising debouncer with rise/fall/any-change pulses
module debouncer_multi #(
  parameter int   WIDTH       = 4,
  parameter int   N           = 4,
  parameter int   PRESCALE    = 1,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] noisy_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int              CW        = (N > 1) ? $clog2(N) : 1;
  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(N - 1);
  localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RESET_VEC = {WIDTH{RESET_VAL}};

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] flip;

  // Per-channel synchroniser chain; the last stage is the filtered view of the pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= RESET_VEC;
      end
    end else begin
      sync_q[0] <= noisy_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Free-running prescaler shared by every channel; tick marks its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // A channel flips when it has mismatched for N ticks, i.e. the counter sits at N-1 on a tick.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (sync_w[i] != clean_out[i]) && tick && (cnt_q[i] == CNT_LAST);
    end
  end

  // Stability counters: cleared on any agreement or on acceptance, advanced only on ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync_w[i] == clean_out[i]) || flip[i]) begin
          cnt_q[i] <= '0;
        end else if (tick) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Clean level and edge pulses are registered together so pulses align with the level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_out  <= RESET_VEC;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      clean_out  <= clean_out ^ flip;
      rise       <= flip & sync_w;
      fall       <= flip & ~sync_w;
      any_change <= |flip;
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - randomized and directed self-checking bench for debouncer_multi
module tb_debouncer_multi;

  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic [3:0] noisy_a, noisy_b;
  logic [3:0] clean_a, rise_a, fall_a;
  logic [3:0] clean_b, rise_b, fall_b;
  logic       any_a, any_b;

  int n_checks;
  int n_errors;

  // reference model state: index 0 = default instance, 1 = PRESCALE=4/N=3 instance
  int         m_n [2];
  int         m_p [2];
  logic [3:0] m_clean [2];
  logic [3:0] m_rise  [2];
  logic [3:0] m_fall  [2];
  logic       m_any   [2];
  int         m_k     [2];
  int         m_start [2][4];
  logic [3:0] m_hist  [2][8];

  int lat, cnt_r, cnt_f, cnt_any, cnt_all;
  logic [3:0] ra, rb;

  debouncer_multi #(.WIDTH(4), .N(4), .PRESCALE(1), .SYNC_STAGES(S), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .noisy_in(noisy_a), .clean_out(clean_a),
    .rise(rise_a), .fall(fall_a), .any_change(any_a)
  );

  debouncer_multi #(.WIDTH(4), .N(3), .PRESCALE(4), .SYNC_STAGES(S), .RESET_VAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .noisy_in(noisy_b), .clean_out(clean_b),
    .rise(rise_b), .fall(fall_b), .any_change(any_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_clean[d] = 4'b0000;
      m_rise[d]  = 4'b0000;
      m_fall[d]  = 4'b0000;
      m_any[d]   = 1'b0;
      m_k[d]     = 0;
      for (int i = 0; i < 4; i++) m_start[d][i] = 0;
    end
  endtask

  // Edge k (counted from reset release) is a tick when (k+1) is a multiple of PRESCALE.
  // A channel accepts its new level on the N-th tick of an unbroken run of disagreement.
  task automatic model_step(input int d, input logic [3:0] nin);
    logic [3:0] sy;
    logic [3:0] fl;
    int k;
    int nticks;
    k  = m_k[d];
    sy = (k >= S) ? m_hist[d][(k - S) % 8] : 4'b0000;
    fl = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (sy[i] == m_clean[d][i]) begin
        m_start[d][i] = k + 1;
      end else begin
        nticks = (k + 1) / m_p[d] - m_start[d][i] / m_p[d];
        if (((k + 1) % m_p[d] == 0) && nticks == m_n[d]) begin
          fl[i] = 1'b1;
          m_start[d][i] = k + 1;
        end
      end
    end
    m_rise[d]  = fl & sy;
    m_fall[d]  = fl & ~sy;
    m_any[d]   = |fl;
    m_clean[d] = m_clean[d] ^ fl;
    m_hist[d][k % 8] = nin;
    m_k[d] = k + 1;
  endtask

  task automatic compare_all();
    check("a_clean", clean_a, m_clean[0]);
    check("a_rise",  rise_a,  m_rise[0]);
    check("a_fall",  fall_a,  m_fall[0]);
    check("a_any",   any_a,   m_any[0]);
    check("b_clean", clean_b, m_clean[1]);
    check("b_rise",  rise_b,  m_rise[1]);
    check("b_fall",  fall_b,  m_fall[1]);
    check("b_any",   any_b,   m_any[1]);
  endtask

  // called at a falling edge: drive, let one rising edge happen, compare at next falling edge
  task automatic cycle(input logic [3:0] na, input logic [3:0] nb);
    noisy_a = na;
    noisy_b = nb;
    @(posedge clk);
    model_step(0, na);
    model_step(1, nb);
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset(input int cycles);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    m_n[0] = 4; m_p[0] = 1;
    m_n[1] = 3; m_p[1] = 4;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    noisy_a = 4'b0000;
    noisy_b = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // 1: quiet inputs after reset release
    cnt_any = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0000, 4'b0000);
      cnt_any += int'(any_a) + int'(any_b);
    end
    check("t1_clean", clean_a, 4'b0000);
    check("t1_no_pulse", cnt_any, 0);

    // 2: channel 0 rises, latency SYNC_STAGES+N = 6 edges
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      cycle(4'b0001, 4'b0000);
      if (lat < 0 && clean_a[0]) begin
        lat = c;
        check("t2_rise", rise_a, 4'b0001);
        check("t2_any", any_a, 1'b1);
        check("t2_others", clean_a[3:1], 3'b000);
      end
    end
    check("t2_latency", lat, 6);

    // 3: 3-cycle glitch on channel 1 rejected, 4-cycle pulse accepted then released
    cnt_r = 0;
    for (int c = 0; c < 3; c++) begin cycle(4'b0011, 4'b0000); cnt_r += int'(rise_a[1]); end
    for (int c = 0; c < 12; c++) begin cycle(4'b0001, 4'b0000); cnt_r += int'(rise_a[1]); end
    check("t3_glitch_rise", cnt_r, 0);
    check("t3_glitch_level", clean_a[1], 1'b0);
    cnt_r = 0;
    cnt_f = 0;
    for (int c = 0; c < 4; c++) begin cycle(4'b0011, 4'b0000); cnt_r += int'(rise_a[1]); end
    for (int c = 0; c < 15; c++) begin
      cycle(4'b0001, 4'b0000);
      cnt_r += int'(rise_a[1]);
      cnt_f += int'(fall_a[1]);
    end
    check("t3_pulse_rise", cnt_r, 1);
    check("t3_pulse_fall", cnt_f, 1);
    check("t3_end_level", clean_a[1], 1'b0);

    // 4: all channels change together
    for (int c = 0; c < 12; c++) cycle(4'b0000, 4'b0000);
    cnt_all = 0;
    cnt_any = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(4'b1111, 4'b0000);
      cnt_all += int'(rise_a == 4'b1111);
      cnt_any += int'(any_a);
    end
    check("t4_rise_all", cnt_all, 1);
    check("t4_any_once", cnt_any, 1);
    check("t4_level", clean_a, 4'b1111);

    // 5: prescaled instance, random phase, latency window and 5-cycle glitch rejection
    for (int c = 0; c < int'($urandom_range(0, 7)); c++) cycle(4'b1111, 4'b0000);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      cycle(4'b1111, 4'b0100);
      if (lat < 0 && clean_b[2]) lat = c;
    end
    check("t5_lat_window", (lat >= 10 && lat <= 16), 1'b1);
    for (int c = 0; c < 20; c++) cycle(4'b1111, 4'b0000);
    cnt_r = 0;
    for (int c = 0; c < 5; c++) begin cycle(4'b1111, 4'b0100); cnt_r += int'(rise_b[2]); end
    for (int c = 0; c < 20; c++) begin cycle(4'b1111, 4'b0000); cnt_r += int'(rise_b[2]); end
    check("t5_glitch_rise", cnt_r, 0);
    check("t5_glitch_level", clean_b[2], 1'b0);

    // 6: reset mid-count with channel 0 high, then refilter from scratch
    for (int c = 0; c < 12; c++) cycle(4'b0000, 4'b0000);
    for (int c = 0; c < 8; c++) cycle(4'b0001, 4'b0000);
    check("t6_pre_level", clean_a[0], 1'b1);
    for (int c = 0; c < 4; c++) cycle(4'b0000, 4'b0000);
    check("t6_mid_level", clean_a[0], 1'b1);
    noisy_a = 4'b0000;
    apply_reset(2);
    check("t6_rst_clean", clean_a, 4'b0000);
    check("t6_rst_fall", fall_a, 4'b0000);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      cycle(4'b0001, 4'b0000);
      if (lat < 0 && clean_a[0]) lat = c;
    end
    check("t6_refilter_latency", lat, 6);

    // random traffic with variable hold times and occasional resets
    ra = 4'b0000;
    rb = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) ra[i] = ~ra[i];
        if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
      end
      if ($urandom_range(0, 9) < 3) begin
        ra = (c % 40 < 20) ? 4'b1010 : 4'b0101;
        rb = (c % 64 < 32) ? 4'b0110 : 4'b1001;
      end
      if ($urandom_range(0, 499) == 0) begin
        noisy_a = ra;
        noisy_b = rb;
        apply_reset(int'($urandom_range(1, 3)));
      end
      cycle(ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
